// File: rtl/mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1
// Description : Registered 4-to-1 lane selector. One of four WIDTH-bit lanes
//               packed in d is chosen by sel and presented on y one clock
//               later. en gates the capture, and y_vld marks that y holds a
//               captured lane since the last reset.
//               Optional feature macro: MUX_4X1_PARITY_EN. When it is defined,
//               the y_par output carries the even parity of the captured lane.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [4*WIDTH-1:0] d,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   y,
    output logic               y_vld
`ifdef MUX_4X1_PARITY_EN
    ,
    output logic               y_par
`endif
);

    // Lane k occupies d[k*WIDTH +: WIDTH].
    logic [WIDTH-1:0] w_lane [4];
    logic [WIDTH-1:0] w_sel_lane;

    logic [WIDTH-1:0] r_y;
    logic             r_vld;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_lane[k] = d[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Combinational lane pick. All four sel codes are covered, so no default is needed.
    always_comb begin
        w_sel_lane = w_lane[0];
        case (sel)
            2'd0: w_sel_lane = w_lane[0];
            2'd1: w_sel_lane = w_lane[1];
            2'd2: w_sel_lane = w_lane[2];
            2'd3: w_sel_lane = w_lane[3];
            default: w_sel_lane = w_lane[0];
        endcase
    end

    // Output register. Reset takes priority over en, and en=0 holds the last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else if (en) begin
            r_y   <= w_sel_lane;
            r_vld <= 1'b1;
        end
    end

    assign y     = r_y;
    assign y_vld = r_vld;

`ifdef MUX_4X1_PARITY_EN
    logic r_par;

    // Parity of the selected lane, registered alongside y so it always describes y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (en) begin
            r_par <= ^w_sel_lane;
        end
    end

    assign y_par = r_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1
// Description : Self-checking bench for mux_4x1. Two instances run in
//               parallel, one with WIDTH=1 and one with WIDTH=8, and they
//               share the control signals. The bench first applies a table of
//               directed vectors and then a randomised stream that is checked
//               against a behavioural model. Expected results go into a
//               scoreboard queue when the stimulus is driven, and they are
//               compared after the capturing edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  d1;
    logic [31:0] d8;
    logic        y1;
    logic        vld1;
    logic [7:0]  y8;
    logic        vld8;
`ifdef MUX_4X1_PARITY_EN
    logic        par1;
    logic        par8;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic [3:0]  dd;
        logic [31:0] dw;
        logic [1:0]  s;
        logic        ey1;
        logic        evld;
        logic [7:0]  ey8;
        logic        epar;
    } vec_t;

    typedef struct {
        logic       y1;
        logic       vld;
        logic [7:0] y8;
        logic       par;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    always #5 clk = ~clk;

    mux_4x1 #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d1),
        .sel   (sel),
        .y     (y1),
        .y_vld (vld1)
`ifdef MUX_4X1_PARITY_EN
        ,
        .y_par (par1)
`endif
    );

    mux_4x1 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d8),
        .sel   (sel),
        .y     (y8),
        .y_vld (vld8)
`ifdef MUX_4X1_PARITY_EN
        ,
        .y_par (par8)
`endif
    );

    // Watchdog so that the run always reaches an end.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic r, input logic e, input logic [3:0] dd,
                       input logic [31:0] dw, input logic [1:0] s,
                       input logic ey1, input logic evld, input logic [7:0] ey8,
                       input logic epar);
        vec_t v;
        v.r = r; v.e = e; v.dd = dd; v.dw = dw; v.s = s;
        v.ey1 = ey1; v.evld = evld; v.ey8 = ey8; v.epar = epar;
        vecs.push_back(v);
    endtask

    task automatic check_one();
        exp_t ex;
        if (expq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: queue empty, got 0 entries, required 1");
            return;
        end
        ex = expq.pop_front();
        checks++;
        if (y1 !== ex.y1) begin
            errors++;
            $display("FAIL y_w1[%0d]: got %b, required %b", ex.idx, y1, ex.y1);
        end
        checks++;
        if (vld1 !== ex.vld) begin
            errors++;
            $display("FAIL vld_w1[%0d]: got %b, required %b", ex.idx, vld1, ex.vld);
        end
        checks++;
        if (y8 !== ex.y8) begin
            errors++;
            $display("FAIL y_w8[%0d]: got %h, required %h", ex.idx, y8, ex.y8);
        end
        checks++;
        if (vld8 !== ex.vld) begin
            errors++;
            $display("FAIL vld_w8[%0d]: got %b, required %b", ex.idx, vld8, ex.vld);
        end
`ifdef MUX_4X1_PARITY_EN
        checks++;
        if (par8 !== ex.par) begin
            errors++;
            $display("FAIL par_w8[%0d]: got %b, required %b", ex.idx, par8, ex.par);
        end
        checks++;
        if (par1 !== ex.y1 && ex.vld) begin
            errors++;
            $display("FAIL par_w1[%0d]: got %b, required %b", ex.idx, par1, ex.y1);
        end
`endif
    endtask

    // Drive one vector just after the falling edge, queue its expectation, then
    // compare 1 time unit after the rising edge that captures it.
    task automatic apply(input vec_t v, input int idx);
        exp_t ex;
        @(negedge clk);
        rst_n = v.r; en = v.e; d1 = v.dd; d8 = v.dw; sel = v.s;
        ex.y1 = v.ey1; ex.vld = v.evld; ex.y8 = v.ey8; ex.par = v.epar; ex.idx = idx;
        expq.push_back(ex);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        logic       m_y1;
        logic       m_vld;
        logic [7:0] m_y8;
        logic       m_par;
        vec_t       v;
        logic [7:0] lane8;

        rst_n = 1'b0; en = 1'b0; sel = 2'd0; d1 = '0; d8 = '0;

        // Reset holds for two edges while en=1.
        add(0, 1, 4'b1111, 32'hFFFF_FFFF, 2'd3, 0, 0, 8'h00, 0);
        add(0, 1, 4'b1111, 32'hFFFF_FFFF, 2'd3, 0, 0, 8'h00, 0);
        // Sweep sel with d=1010 on the 1-bit instance and {81,07,FF,3C} on the 8-bit one.
        add(1, 1, 4'b1010, 32'h8107_FF3C, 2'd0, 0, 1, 8'h3C, 0);
        add(1, 1, 4'b1010, 32'h8107_FF3C, 2'd1, 1, 1, 8'hFF, 0);
        add(1, 1, 4'b1010, 32'h8107_FF3C, 2'd2, 0, 1, 8'h07, 1);
        add(1, 1, 4'b1010, 32'h8107_FF3C, 2'd3, 1, 1, 8'h81, 0);
        // d=1101 swept, and a second 8-bit pattern.
        add(1, 1, 4'b1101, 32'h0102_0304, 2'd0, 1, 1, 8'h04, 1);
        add(1, 1, 4'b1101, 32'h0102_0304, 2'd1, 0, 1, 8'h03, 0);
        add(1, 1, 4'b1101, 32'h0102_0304, 2'd2, 1, 1, 8'h02, 1);
        add(1, 1, 4'b1101, 32'h0102_0304, 2'd3, 1, 1, 8'h01, 1);
        // Hold: capture, then en=0 for 3 edges with changed inputs, then capture again.
        add(1, 1, 4'b1101, 32'h0102_0304, 2'd0, 1, 1, 8'h04, 1);
        add(1, 0, 4'b0000, 32'h0000_0000, 2'd1, 1, 1, 8'h04, 1);
        add(1, 0, 4'b0000, 32'h0000_0000, 2'd1, 1, 1, 8'h04, 1);
        add(1, 0, 4'b0000, 32'h0000_0000, 2'd1, 1, 1, 8'h04, 1);
        add(1, 1, 4'b0000, 32'h0000_0000, 2'd1, 0, 1, 8'h00, 0);
        // Mid-run reset while streaming sel=3.
        add(1, 1, 4'b1000, 32'hAA00_0000, 2'd3, 1, 1, 8'hAA, 0);
        add(1, 1, 4'b1000, 32'hAA00_0000, 2'd3, 1, 1, 8'hAA, 0);
        add(0, 1, 4'b1000, 32'hAA00_0000, 2'd3, 0, 0, 8'h00, 0);
        add(1, 1, 4'b1000, 32'hAA00_0000, 2'd3, 1, 1, 8'hAA, 0);
        // Reset with en=0, then hold keeps y_vld low until the first capture.
        add(0, 0, 4'b0010, 32'h0000_5500, 2'd1, 0, 0, 8'h00, 0);
        add(1, 0, 4'b0010, 32'h0000_5500, 2'd1, 0, 0, 8'h00, 0);
        add(1, 1, 4'b0010, 32'h0000_5500, 2'd1, 1, 1, 8'h55, 0);
        // d and sel change together; new sel applies to new d.
        add(1, 1, 4'b0100, 32'h00E1_0000, 2'd2, 1, 1, 8'hE1, 0);
        add(1, 1, 4'b0001, 32'h0000_0070, 2'd0, 1, 1, 8'h70, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Randomised stream checked against a behavioural model. The first
        // vector always resets so that the model starts in a known state.
        m_y1 = 1'b0; m_vld = 1'b0; m_y8 = 8'h00; m_par = 1'b0;
        for (int i = 0; i < 60; i++) begin
            v.r  = (i == 0) ? 1'b0 : ($urandom_range(0, 9) != 0);
            v.e  = ($urandom_range(0, 3) != 0);
            v.dd = 4'($urandom);
            v.dw = $urandom;
            v.s  = 2'($urandom);
            lane8 = v.dw[8*v.s +: 8];
            if (!v.r) begin
                m_y1 = 1'b0; m_vld = 1'b0; m_y8 = 8'h00; m_par = 1'b0;
            end else if (v.e) begin
                m_y1  = v.dd[v.s];
                m_vld = 1'b1;
                m_y8  = lane8;
                m_par = ^lane8;
            end
            v.ey1 = m_y1; v.evld = m_vld; v.ey8 = m_y8; v.epar = m_par;
            apply(v, 1000 + i);
        end

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
